// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES key schedule for 128/192/256-bit keys.
// One 32-bit schedule word is produced per clock into an internal round-key
// store; any round key is then served combinationally through rd_idx/rd_key.
// Optional feature macro: KEY_EXP_ZEROIZE_EN adds a synchronous zeroize input
// that wipes the store, the working register and Rcon.

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int unsigned n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // a^254 == a^-1 for nonzero a, and 0 maps to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int unsigned n = 1; n < 8; n++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Substitute one byte
  always_comb begin
    out_o = affine(gf_inv(in_i));
  end

endmodule

module aes_key_expander #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic [3:0]          rd_idx,
  output logic [127:0]        rd_key,
  output logic                busy,
  output logic                done
`ifdef KEY_EXP_ZEROIZE_EN
  ,
  input  logic                zeroize
`endif
);

  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned AW = 6;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [2:0]    pos_q, pos_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [31:0]   wprev_q, wprev_d;
  logic [31:0]   store_q [NW];

  logic          load_key;
  logic          exp_we;
  logic          clr;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   temp;
  logic [31:0]   w_back;
  logic [31:0]   new_word;

`ifdef KEY_EXP_ZEROIZE_EN
  assign clr = zeroize;
`else
  assign clr = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubWord input: rotated previous word at the start of each Nk group
  always_comb begin
    sub_in = (pos_q == 3'd0) ? {wprev_q[7:0], wprev_q[31:8]} : wprev_q;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sub_in[8*b +: 8]),
      .out_o (sub_out[8*b +: 8])
    );
  end

  // Schedule word recurrence w[i] = w[i-Nk] ^ t
  always_comb begin
    temp = wprev_q;
    if (pos_q == 3'd0) begin
      temp = sub_out ^ {24'h0, rcon_q};
    end else if ((NK == 8) && (pos_q == 3'd4)) begin
      temp = sub_out;
    end
    // idx_q is held within [NK, NW-1], so this index never underflows
    w_back   = store_q[idx_q - AW'(NK)];
    new_word = w_back ^ temp;
  end

  // Control next-state: key load on accepted start, one word per EXPAND cycle
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    rcon_d   = rcon_q;
    wprev_d  = wprev_q;
    load_key = 1'b0;
    exp_we   = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      idx_d   = AW'(NK);
      pos_d   = '0;
      rcon_d  = '0;
      wprev_d = '0;
    end else begin
      case (state_q)
        S_EXPAND: begin
          exp_we  = 1'b1;
          wprev_d = new_word;
          if (pos_q == 3'(NK - 1)) pos_d = '0;
          else                     pos_d = pos_q + 3'd1;
          if (pos_q == 3'd0) rcon_d = xtime(rcon_q);
          if (idx_q == AW'(NW - 1)) state_d = S_DONE;
          else                      idx_d   = idx_q + AW'(1);
        end
        default: begin
          if (start) begin
            load_key = 1'b1;
            state_d  = S_EXPAND;
            idx_d    = AW'(NK);
            pos_d    = '0;
            rcon_d   = 8'h01;
            wprev_d  = key_in[KEY_BITS-1 -: 32];
          end
        end
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= AW'(NK);
      pos_q   <= '0;
      rcon_q  <= 8'h01;
      wprev_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      rcon_q  <= rcon_d;
      wprev_q <= wprev_d;
    end
  end

  // Round-key store: cleared on reset/zeroize, key words on load, one schedule word per EXPAND cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < NW; n++) store_q[n] <= '0;
    end else if (clr) begin
      for (int unsigned n = 0; n < NW; n++) store_q[n] <= '0;
    end else if (load_key) begin
      for (int unsigned n = 0; n < NK; n++) store_q[n] <= key_in[32*n +: 32];
    end else if (exp_we) begin
      store_q[idx_q] <= new_word;
    end
  end

  // Combinational round-key read; indices beyond Nr read as zero
  always_comb begin
    rd_key = '0;
    if (rd_idx <= 4'(NR)) begin
      for (int unsigned j = 0; j < 4; j++) begin
        rd_key[32*j +: 32] = store_q[{rd_idx, 2'(j)}];
      end
    end
  end

  assign busy = (state_q == S_EXPAND);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: one instance per key size, a
// FIPS-197-level reference model of the schedule and store contents, a
// per-cycle compare process, and literal known-answer checks.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   start_v;
  logic [2:0]   zeroize_v;
  logic [2:0]   busy_v;
  logic [2:0]   done_v;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [3:0]   rdi [3];
  logic [127:0] rdk [3];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  aes_key_expander #(.KEY_BITS(128)) u_d128 (
    .clk(clk), .rst(rst), .start(start_v[0]), .key_in(key128), .rd_idx(rdi[0]),
    .rd_key(rdk[0]), .busy(busy_v[0]), .done(done_v[0])
`ifdef KEY_EXP_ZEROIZE_EN
    , .zeroize(zeroize_v[0])
`endif
  );

  aes_key_expander #(.KEY_BITS(192)) u_d192 (
    .clk(clk), .rst(rst), .start(start_v[1]), .key_in(key192), .rd_idx(rdi[1]),
    .rd_key(rdk[1]), .busy(busy_v[1]), .done(done_v[1])
`ifdef KEY_EXP_ZEROIZE_EN
    , .zeroize(zeroize_v[1])
`endif
  );

  aes_key_expander #(.KEY_BITS(256)) u_d256 (
    .clk(clk), .rst(rst), .start(start_v[2]), .key_in(key256), .rd_idx(rdi[2]),
    .rd_key(rdk[2]), .busy(busy_v[2]), .done(done_v[2])
`ifdef KEY_EXP_ZEROIZE_EN
    , .zeroize(zeroize_v[2])
`endif
  );

  // ---------------- reference model ----------------
  logic [7:0]  sbm [256];
  logic [31:0] sched  [3][60];
  logic [31:0] mstore [3][60];
  bit          act [3];
  int          cyc [3];

  function automatic int nk_of(input int k);
    return 4 + 2 * k;
  endfunction

  function automatic int nw_of(input int k);
    return 4 * (nk_of(k) + 7);
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    logic [7:0] c;
    logic [7:0] r;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      r[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8] ^ c[i];
    return r;
  endfunction

  // S-box from first principles: brute-force inverse search then affine map
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbm[x] = affine(inv);
    end
  endfunction

  // Big-endian (FIPS notation) word operations
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbm[w[31:24]], sbm[w[23:16]], sbm[w[15:8]], sbm[w[7:0]]};
  endfunction

  function automatic void build_sched(input int k, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    int nw;
    nk = nk_of(k);
    nw = nw_of(k);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = bswap(key[32*i +: 32]);
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) sched[k][i] = bswap(w[i]);
  endfunction

  function automatic logic [255:0] key_of(input int k);
    if (k == 0) return {128'h0, key128};
    if (k == 1) return {64'h0, key192};
    return key256;
  endfunction

  function automatic bit exp_busy(input int k);
    return act[k] && (cyc[k] <= nw_of(k) - nk_of(k));
  endfunction

  function automatic bit exp_done(input int k);
    return act[k] && (cyc[k] > nw_of(k) - nk_of(k));
  endfunction

  function automatic logic [127:0] exp_rd(input int k, input logic [3:0] r);
    logic [127:0] v;
    v = '0;
    if (int'(r) <= nk_of(k) + 6)
      for (int j = 0; j < 4; j++) v[32*j +: 32] = mstore[k][4*int'(r) + j];
    return v;
  endfunction

  // Model timeline: cycle c of an expansion writes schedule word Nk+c-1
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst || zeroize_v[k]) begin
        act[k] = 1'b0;
        cyc[k] = 0;
        for (int i = 0; i < 60; i++) mstore[k][i] = '0;
      end else if (start_v[k] && !exp_busy(k)) begin
        build_sched(k, key_of(k));
        for (int i = 0; i < nk_of(k); i++) mstore[k][i] = sched[k][i];
        act[k] = 1'b1;
        cyc[k] = 1;
      end else if (exp_busy(k)) begin
        mstore[k][nk_of(k) + cyc[k] - 1] = sched[k][nk_of(k) + cyc[k] - 1];
        cyc[k] = cyc[k] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act_v, input logic [127:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act_v, exp_v);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy[%0d]", k), 128'(busy_v[k]), 128'(exp_busy(k)));
        chk($sformatf("done[%0d]", k), 128'(done_v[k]), 128'(exp_done(k)));
        chk($sformatf("rd_key[%0d] idx %0d", k, rdi[k]), rdk[k], exp_rd(k, rdi[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    return {bswap(d), bswap(c), bswap(b), bswap(a)};
  endfunction

  task automatic zero_sweep(input string nm);
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 3; k++) rdi[k] = 4'(r);
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk($sformatf("%s[%0d] idx %0d", nm, k, r), rdk[k], 128'h0);
      step();
    end
  endtask

  // Known-answer expansion of all three FIPS-197 keys; caller is just past an edge
  task automatic run_fips(input string tag);
    int first [3];
    int n;
    key128 = {bswap(32'h09cf4f3c), bswap(32'habf71588), bswap(32'h28aed2a6), bswap(32'h2b7e1516)};
    key192 = {bswap(32'h522c6b7b), bswap(32'h62f8ead2), bswap(32'h809079e5),
              bswap(32'hc810f32b), bswap(32'hda0e6452), bswap(32'h8e73b0f7)};
    key256 = {bswap(32'h0914dff4), bswap(32'h2d9810a3), bswap(32'h3b6108d7), bswap(32'h1f352c07),
              bswap(32'h857d7781), bswap(32'h2b73aef0), bswap(32'h15ca71be), bswap(32'h603deb10)};
    start_v = 3'b111;
    step();
    start_v = 3'b000;
    first = '{-1, -1, -1};
    n = 1;
    while (n <= 80 && (first[0] < 0 || first[1] < 0 || first[2] < 0)) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (done_v[k] && first[k] < 0) first[k] = n;
      step();
      n++;
    end
    chk({tag, " done_cycle_128"}, 128'(first[0]), 128'(41));
    chk({tag, " done_cycle_192"}, 128'(first[1]), 128'(47));
    chk({tag, " done_cycle_256"}, 128'(first[2]), 128'(53));
    rdi[0] = 4'd10;
    rdi[1] = 4'd12;
    rdi[2] = 4'd14;
    @(negedge clk);
    chk({tag, " kat128_r10"}, rdk[0], rk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));
    chk({tag, " kat192_r12"}, rdk[1], rk(32'he98ba06f, 32'h448c773c, 32'h8ecc7204, 32'h01002202));
    chk({tag, " kat256_r14"}, rdk[2], rk(32'hfe4890d1, 32'he6188d0b, 32'h046df344, 32'h706c631e));
    step();
    rdi[0] = 4'd1;
    @(negedge clk);
    chk({tag, " kat128_r1"}, rdk[0], rk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));
    step();
  endtask

  initial begin
    rst       = 1'b1;
    start_v   = '0;
    zeroize_v = '0;
    key128    = '0;
    key192    = '0;
    key256    = '0;
    for (int k = 0; k < 3; k++) rdi[k] = 4'd0;
    build_sbox();
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset busy", 128'(busy_v), 128'h0);
    chk("reset done", 128'(done_v), 128'h0);
    step();
    rst = 1'b0;
    zero_sweep("reset_zero");

    run_fips("first");

    // Expansion with an ignored mid-run start, then reset in cycle 20
    start_v = 3'b001;
    step();
    start_v = 3'b000;
    repeat (9) step();
    start_v = 3'b001;
    step();
    start_v = 3'b000;
    repeat (9) step();
    chk("busy before abort", 128'(busy_v[0]), 128'h1);
    rst = 1'b1;
    #1;
    chk("async reset busy", 128'(busy_v[0]), 128'h0);
    chk("async reset rd_key", rdk[0], 128'h0);
    step();
    rst = 1'b0;
    zero_sweep("abort_zero");
    run_fips("rerun");

    // Randomised traffic: random keys, starts (some while busy), reads and rare resets
    repeat (600) begin
      for (int k = 0; k < 3; k++) begin
        start_v[k] = ($urandom_range(0, 24) == 0);
        rdi[k]     = 4'($urandom_range(0, 15));
      end
      key128 = {$urandom, $urandom, $urandom, $urandom};
      key192 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      key256 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rst    = ($urandom_range(0, 299) == 0);
      step();
    end
    start_v = '0;
    rst     = 1'b0;
    repeat (70) begin
      for (int k = 0; k < 3; k++) rdi[k] = 4'($urandom_range(0, 15));
      step();
    end

    run_fips("final");
    for (int k = 0; k < 3; k++) rdi[k] = 4'd15;
    @(negedge clk);
    chk("done with idx15", 128'(done_v), 128'h7);
    for (int k = 0; k < 3; k++) chk($sformatf("idx15[%0d]", k), rdk[k], 128'h0);
    step();

`ifdef KEY_EXP_ZEROIZE_EN
    zeroize_v = 3'b111;
    start_v   = 3'b111;
    step();
    zeroize_v = 3'b000;
    start_v   = 3'b000;
    @(negedge clk);
    chk("zeroize done", 128'(done_v), 128'h0);
    chk("zeroize busy", 128'(busy_v), 128'h0);
    step();
    zero_sweep("zeroize_zero");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
